bldc_startup_sequencer: RTL and testbench

Sequences the open-loop phase commutator from standstill to hall-driven running. It drives the commutator's `hall_signal` and `speed_set` inputs. From IDLE it aligns the rotor, then force-commutates with a shrinking step period and a slew-limited duty ramp. It hands over to synchronized hall feedback once the feedback matches the forced step. It supervises stall, invalid-hall and failed-handover faults, and sits between the speed-command register and the commutator.

---
 rtl/bldc_startup_sequencer_if.sv | 23 ++
 rtl/bldc_startup_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_bldc_startup_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bldc_startup_sequencer_if.sv
// Control/status bundle between the speed-command side, the hall sensors and the
// startup sequencer; the sequencer takes the slave view.
interface bldc_startup_sequencer_if;
   logic       enable;
   logic [7:0] speed_cmd;
   logic [2:0] hall_in;
   logic [2:0] hall_signal;
   logic [7:0] speed_set;
   logic [2:0] state;
   logic       running;
   logic       fault;
   logic [1:0] fault_code;

   modport master (
      output enable, speed_cmd, hall_in,
      input  hall_signal, speed_set, state, running, fault, fault_code
   );

   modport slave (
      input  enable, speed_cmd, hall_in,
      output hall_signal, speed_set, state, running, fault, fault_code
   );
endinterface

// File: rtl/bldc_startup_sequencer.sv
// Open-loop BLDC startup: align, forced commutation with shrinking period and
// slewed duty, handover to synchronized hall feedback, with fault supervision.
module bldc_startup_sequencer #(
   parameter int unsigned ALIGN_CYCLES = 1000,
   parameter logic [7:0]  ALIGN_DUTY   = 8'd40,
   parameter logic [15:0] START_PERIOD = 16'd20000,
   parameter logic [15:0] MIN_PERIOD   = 16'd4000,
   parameter logic [15:0] PERIOD_DEC   = 16'd500,
   parameter logic [15:0] RAMP_DIV     = 16'd256,
   parameter logic [7:0]  MAX_STEPS    = 8'd60,
   parameter logic [23:0] STALL_CYCLES = 24'd200000
) (
   input  logic                     clk,
   input  logic                     rst,
   bldc_startup_sequencer_if.slave  ctl
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_RAMP   = 3'd2,
      S_CLOSED = 3'd3,
      S_FAULT  = 3'd4
   } state_e;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_HALL     = 2'd1;
   localparam logic [1:0] FC_HANDOVER = 2'd2;
   localparam logic [1:0] FC_STALL    = 2'd3;

   state_e      state_q, state_d;
   logic [2:0]  hall_meta_q, hs_q;
   logic [2:0]  hall_q, hall_d;
   logic [7:0]  speed_q, speed_d;
   logic [1:0]  code_q, code_d;
   logic        running_q, running_d;
   logic        fault_q, fault_d;
   logic [31:0] align_cnt_q, align_cnt_d;
   logic [15:0] step_cnt_q, step_cnt_d;
   logic [15:0] period_q, period_d;
   logic [7:0]  steps_q, steps_d;
   logic [15:0] div_q, div_d;
   logic [23:0] stall_q, stall_d;

   logic [7:0]  slew_duty;
   logic        div_tick;
   logic        hall_valid;
   logic [15:0] period_next;

   function automatic logic [2:0] next_hall(input logic [2:0] h);
      case (h)
         3'b001:  return 3'b011;
         3'b011:  return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         hall_meta_q <= '0;
         hs_q        <= '0;
         state_q     <= S_IDLE;
         hall_q      <= '0;
         speed_q     <= '0;
         code_q      <= FC_NONE;
         running_q   <= 1'b0;
         fault_q     <= 1'b0;
         align_cnt_q <= '0;
         step_cnt_q  <= '0;
         period_q    <= '0;
         steps_q     <= '0;
         div_q       <= '0;
         stall_q     <= '0;
      end else begin
         hall_meta_q <= ctl.hall_in;
         hs_q        <= hall_meta_q;
         state_q     <= state_d;
         hall_q      <= hall_d;
         speed_q     <= speed_d;
         code_q      <= code_d;
         running_q   <= running_d;
         fault_q     <= fault_d;
         align_cnt_q <= align_cnt_d;
         step_cnt_q  <= step_cnt_d;
         period_q    <= period_d;
         steps_q     <= steps_d;
         div_q       <= div_d;
         stall_q     <= stall_d;
      end
   end

   always_comb begin
      slew_duty = speed_q;
      if (speed_q < ctl.speed_cmd) begin
         slew_duty = speed_q + 8'd1;
      end else if (speed_q > ctl.speed_cmd) begin
         slew_duty = speed_q - 8'd1;
      end
      div_tick   = (div_q == RAMP_DIV - 16'd1);
      hall_valid = (hs_q != 3'b000) && (hs_q != 3'b111);
      // 17-bit compare keeps MIN_PERIOD + PERIOD_DEC from wrapping
      if ({1'b0, period_q} >= ({1'b0, MIN_PERIOD} + {1'b0, PERIOD_DEC})) begin
         period_next = period_q - PERIOD_DEC;
      end else begin
         period_next = MIN_PERIOD;
      end

      state_d     = state_q;
      hall_d      = hall_q;
      speed_d     = speed_q;
      code_d      = code_q;
      align_cnt_d = '0;
      step_cnt_d  = '0;
      period_d    = period_q;
      steps_d     = steps_q;
      div_d       = '0;
      stall_d     = '0;

      unique case (state_q)
         S_IDLE: begin
            hall_d   = '0;
            speed_d  = '0;
            code_d   = FC_NONE;
            period_d = '0;
            steps_d  = '0;
            if (ctl.enable) begin
               state_d = S_ALIGN;
               hall_d  = 3'b001;
               speed_d = ALIGN_DUTY;
            end
         end

         S_ALIGN: begin
            if (!ctl.enable) begin
               state_d  = S_IDLE;
               hall_d   = '0;
               speed_d  = '0;
               period_d = '0;
               steps_d  = '0;
            end else if (align_cnt_q == ALIGN_CYCLES - 1) begin
               state_d  = S_RAMP;
               hall_d   = 3'b011;
               period_d = START_PERIOD;
               steps_d  = '0;
            end else begin
               align_cnt_d = align_cnt_q + 32'd1;
            end
         end

         S_RAMP: begin
            if (!ctl.enable) begin
               state_d  = S_IDLE;
               hall_d   = '0;
               speed_d  = '0;
               period_d = '0;
               steps_d  = '0;
            end else begin
               div_d = div_tick ? '0 : div_q + 16'd1;
               if (div_tick) begin
                  speed_d = slew_duty;
               end
               if (step_cnt_q == period_q - 16'd1) begin
                  if ((period_q == MIN_PERIOD) && (hs_q == hall_q)) begin
                     state_d = S_CLOSED;
                     hall_d  = hs_q;
                  end else if (steps_q == MAX_STEPS - 8'd1) begin
                     state_d  = S_FAULT;
                     code_d   = FC_HANDOVER;
                     hall_d   = '0;
                     speed_d  = '0;
                     div_d    = '0;
                     period_d = '0;
                     steps_d  = '0;
                  end else begin
                     hall_d   = next_hall(hall_q);
                     period_d = period_next;
                     steps_d  = steps_q + 8'd1;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 16'd1;
               end
            end
         end

         S_CLOSED: begin
            if (!ctl.enable) begin
               state_d  = S_IDLE;
               hall_d   = '0;
               speed_d  = '0;
               period_d = '0;
               steps_d  = '0;
            end else if (!hall_valid ||
                         ((hs_q == hall_q) && (stall_q == STALL_CYCLES - 24'd1))) begin
               state_d  = S_FAULT;
               code_d   = hall_valid ? FC_STALL : FC_HALL;
               hall_d   = '0;
               speed_d  = '0;
               period_d = '0;
               steps_d  = '0;
            end else begin
               // hall_q holds last cycle's hs, so a mismatch marks a fresh hall edge
               hall_d  = hs_q;
               stall_d = (hs_q != hall_q) ? '0 : stall_q + 24'd1;
               div_d   = div_tick ? '0 : div_q + 16'd1;
               if (div_tick) begin
                  speed_d = slew_duty;
               end
            end
         end

         S_FAULT: begin
            hall_d  = '0;
            speed_d = '0;
            if (!ctl.enable) begin
               state_d = S_IDLE;
               code_d  = FC_NONE;
            end
         end

         default: begin
            state_d  = S_IDLE;
            hall_d   = '0;
            speed_d  = '0;
            code_d   = FC_NONE;
            period_d = '0;
            steps_d  = '0;
         end
      endcase

      running_d = (state_d == S_CLOSED);
      fault_d   = (state_d == S_FAULT);
   end

   assign ctl.hall_signal = hall_q;
   assign ctl.speed_set   = speed_q;
   assign ctl.state       = state_q;
   assign ctl.running     = running_q;
   assign ctl.fault       = fault_q;
   assign ctl.fault_code  = code_q;

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// Directed bench for bldc_startup_sequencer using short test-plan parameters;
// edge numbers below count from the first edge that samples enable high.
module tb_bldc_startup_sequencer;

   logic clk = 1'b0;
   logic rst;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   bldc_startup_sequencer_if bus ();

   bldc_startup_sequencer #(
      .ALIGN_CYCLES (8),
      .ALIGN_DUTY   (8'd40),
      .START_PERIOD (16'd20),
      .MIN_PERIOD   (16'd10),
      .PERIOD_DEC   (16'd5),
      .RAMP_DIV     (16'd4),
      .MAX_STEPS    (8'd12),
      .STALL_CYCLES (24'd50)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ctl (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clk_edges(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] want, input int unsigned budget, input string tag);
      int unsigned n = 0;
      while (bus.state != want && n < budget) begin
         clk_edges(1);
         n++;
      end
      check_eq(tag, bus.state, want);
   endtask

   task automatic check_outputs(input string tag, input logic [2:0] st, input logic [2:0] hall,
                                input logic [7:0] spd, input logic [1:0] code);
      check_eq({tag, "_state"}, bus.state, st);
      check_eq({tag, "_hall"}, bus.hall_signal, hall);
      check_eq({tag, "_speed"}, bus.speed_set, spd);
      check_eq({tag, "_running"}, bus.running, (st == 3'd3));
      check_eq({tag, "_fault"}, bus.fault, (st == 3'd4));
      check_eq({tag, "_code"}, bus.fault_code, code);
   endtask

   // From IDLE with enable low: forced steps end at 28, 43, 53, 63; hall matches at 63.
   task automatic run_to_closed(input string tag);
      bus.hall_in = 3'b000;
      bus.enable  = 1'b1;
      clk_edges(54);
      bus.hall_in = 3'b011;
      clk_edges(10);
      check_eq(tag, bus.state, 3'd3);
   endtask

   initial begin
      rst           = 1'b1;
      bus.enable    = 1'b0;
      bus.speed_cmd = 8'd44;
      bus.hall_in   = 3'b000;
      clk_edges(2);
      check_outputs("reset", 3'd0, 3'b000, 8'd0, 2'd0);
      rst = 1'b0;
      clk_edges(1);
      check_eq("idle_hold", bus.state, 3'd0);

      bus.enable = 1'b1;
      clk_edges(1);
      check_outputs("align_e0", 3'd1, 3'b001, 8'd40, 2'd0);
      clk_edges(7);
      check_outputs("align_e7", 3'd1, 3'b001, 8'd40, 2'd0);
      clk_edges(1);
      check_outputs("ramp_e8", 3'd2, 3'b011, 8'd40, 2'd0);
      clk_edges(3);
      check_eq("slew_e11", bus.speed_set, 8'd40);
      clk_edges(1);
      check_eq("slew_e12", bus.speed_set, 8'd41);
      clk_edges(3);
      check_eq("slew_e15", bus.speed_set, 8'd41);
      clk_edges(1);
      check_eq("slew_e16", bus.speed_set, 8'd42);
      clk_edges(4);
      check_eq("slew_e20", bus.speed_set, 8'd43);
      clk_edges(4);
      check_eq("slew_e24", bus.speed_set, 8'd44);
      clk_edges(3);
      check_eq("step1_e27", bus.hall_signal, 3'b011);
      clk_edges(1);
      check_eq("step1_e28", bus.hall_signal, 3'b010);
      check_eq("slew_hold", bus.speed_set, 8'd44);
      clk_edges(14);
      check_eq("step2_e42", bus.hall_signal, 3'b010);
      clk_edges(1);
      check_eq("step2_e43", bus.hall_signal, 3'b001);
      clk_edges(9);
      check_eq("step3_e52", bus.hall_signal, 3'b001);
      clk_edges(1);
      check_eq("step3_e53", bus.hall_signal, 3'b011);
      bus.hall_in = 3'b011;
      clk_edges(9);
      check_eq("handover_e62", bus.state, 3'd2);
      clk_edges(1);
      check_outputs("handover_e63", 3'd3, 3'b011, 8'd44, 2'd0);

      clk_edges(2);
      bus.hall_in = 3'b010;
      clk_edges(2);
      check_eq("latency_2clk", bus.hall_signal, 3'b011);
      clk_edges(1);
      check_eq("latency_3clk", bus.hall_signal, 3'b010);

      clk_edges(2);
      bus.hall_in = 3'b111;
      clk_edges(2);
      check_eq("badhall_pre", bus.state, 3'd3);
      clk_edges(1);
      check_outputs("badhall", 3'd4, 3'b000, 8'd0, 2'd1);

      clk_edges(10);
      check_outputs("fault_hold", 3'd4, 3'b000, 8'd0, 2'd1);
      bus.enable = 1'b0;
      clk_edges(1);
      check_outputs("fault_clear", 3'd0, 3'b000, 8'd0, 2'd0);

      bus.hall_in = 3'b000;
      bus.enable  = 1'b1;
      clk_edges(143);
      check_eq("hofail_e142", bus.state, 3'd2);
      clk_edges(1);
      check_outputs("hofail_e143", 3'd4, 3'b000, 8'd0, 2'd2);
      bus.enable = 1'b0;
      clk_edges(1);
      check_outputs("hofail_clear", 3'd0, 3'b000, 8'd0, 2'd0);

      bus.enable = 1'b1;
      clk_edges(21);
      check_eq("abort_pre", bus.state, 3'd2);
      bus.enable = 1'b0;
      clk_edges(1);
      check_outputs("abort", 3'd0, 3'b000, 8'd0, 2'd0);

      // A hall edge 30 clocks into CLOSED pushes the stall deadline out.
      run_to_closed("stall_entry");
      clk_edges(30);
      bus.hall_in = 3'b010;
      clk_edges(48);
      check_eq("stall_restart", bus.state, 3'd3);
      wait_state(3'd4, 8, "stall_fault");
      check_outputs("stall", 3'd4, 3'b000, 8'd0, 2'd3);
      bus.enable = 1'b0;
      clk_edges(1);
      check_eq("stall_clear", bus.state, 3'd0);

      run_to_closed("rst_entry");
      clk_edges(2);
      check_eq("rst_pre_speed", bus.speed_set, 8'd44);
      rst = 1'b1;
      clk_edges(1);
      check_outputs("rst_mid", 3'd0, 3'b000, 8'd0, 2'd0);
      clk_edges(3);
      check_eq("rst_hold", bus.state, 3'd0);
      rst        = 1'b0;
      bus.enable = 1'b0;
      clk_edges(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
